// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a 1-cycle-latency, byte-strobed data_mem.
// One request in flight; loads respond through a registered, backpressured response.
module dmem_lsu #(
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        mem_re,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [15:0] err_count
);
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_LWAIT, S_RESP} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        fault;
  logic [31:0] word_addr;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign word_addr = {req_addr[31:2], 2'b00};

  always_comb begin
    fault = 1'b0;
    if (req_size == 2'b11)                             fault = 1'b1;
    if (req_size == 2'b01 && req_addr[0])              fault = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)   fault = 1'b1;
    if (req_addr >= 32'(DMEM_BYTES))                   fault = 1'b1;
  end

  assign mem_we    = accept && !fault && req_we;
  assign mem_re    = accept && !fault && !req_we;
  assign mem_waddr = word_addr;
  assign mem_raddr = word_addr;

  // Per-byte-lane store replication and strobe selection.
  logic [NUM_LANES-1:0][7:0] wlane;
  logic [NUM_LANES-1:0]      wsel;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] L = 2'(g);
    logic [7:0] d;
    logic       s;
    always_comb begin
      d = req_wdata[8*g +: 8];
      s = 1'b1;
      case (req_size)
        2'b00: begin
          d = req_wdata[7:0];
          s = (req_addr[1:0] == L);
        end
        2'b01: begin
          d = L[0] ? req_wdata[15:8] : req_wdata[7:0];
          s = (req_addr[1] == L[1]);
        end
        default: begin
          d = req_wdata[8*g +: 8];
          s = 1'b1;
        end
      endcase
    end
    assign wlane[g] = d;
    assign wsel[g]  = s;
  end

  assign mem_wdata = wlane;
  assign mem_wstrb = mem_we ? wsel : 4'b0000;

  // Lane extraction and extension of the returned word.
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ldata;

  always_comb begin
    rbyte = mem_rdata[{off_q, 3'b000} +: 8];
    rhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ldata = uns_q ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ldata = uns_q ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ldata = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_rd    <= 5'd0;
      rsp_err   <= 1'b0;
      err_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (fault) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_rd    <= req_rd;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              state     <= S_RESP;
            end else if (!req_we) begin
              size_q <= req_size;
              uns_q  <= req_unsigned;
              off_q  <= req_addr[1:0];
              rsp_rd <= req_rd;
              state  <= S_LWAIT;
            end
          end
        end
        S_LWAIT: begin
          rsp_data  <= ldata;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: stores, extended loads, faults, backpressure, reset, saturation.
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        mem_re;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:1023];

  dmem_lsu #(.DMEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // data_mem: 1-cycle read latency, byte-strobed writes
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_waddr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re) mem_rdata <= mem[mem_raddr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns; req_rd = rd;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [3:0] estrb, input logic [31:0] ewd);
    @(negedge clk);
    drive(1'b1, addr, wd, sz, 1'b0, 5'd0);
    #1;
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_strb"}, 32'(mem_wstrb), 32'(estrb));
    chk({tag, "_wdata"}, mem_wdata, ewd);
    chk({tag, "_waddr"}, mem_waddr, {addr[31:2], 2'b00});
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_novalid"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [4:0] rd, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b0, addr, 32'd0, sz, uns, rd);
    #1;
    chk({tag, "_re"}, 32'(mem_re), 32'd1);
    chk({tag, "_raddr"}, mem_raddr, {addr[31:2], 2'b00});
    @(negedge clk);
    idle_req();
    #1;
    chk({tag, "_t1_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_t2_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rd"}, 32'(rsp_rd), 32'(rd));
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] sz, input logic [4:0] rd);
    @(negedge clk);
    drive(we, addr, 32'hDEAD_BEEF, sz, 1'b0, rd);
    #1;
    chk({tag, "_nore"}, 32'(mem_re), 32'd0);
    chk({tag, "_nowe"}, 32'(mem_we), 32'd0);
    chk({tag, "_nostrb"}, 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    idle_req();
    #1;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(rsp_err), 32'd1);
    chk({tag, "_data"}, rsp_data, 32'd0);
    chk({tag, "_rd"}, 32'(rsp_rd), 32'(rd));
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_rd", 32'(rsp_rd), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    // byte store then signed byte load of the same word in the next cycle
    do_store("sb103", 32'h103, 32'h0000_00A5, 2'b00, 4'b1000, 32'hA5A5_A5A5);
    do_load("lb103", 32'h103, 2'b00, 1'b0, 5'd3, 32'hFFFF_FFA5);

    do_store("sw40", 32'h40, 32'h8001_7F80, 2'b10, 4'b1111, 32'h8001_7F80);
    do_load("lhu42", 32'h42, 2'b01, 1'b1, 5'd4, 32'h0000_8001);
    do_load("lh40", 32'h40, 2'b01, 1'b0, 5'd5, 32'h0000_7F80);
    do_load("lb40", 32'h40, 2'b00, 1'b0, 5'd6, 32'hFFFF_FF80);
    do_load("lbu43", 32'h43, 2'b00, 1'b1, 5'd7, 32'h0000_0080);
    do_load("lb42", 32'h42, 2'b00, 1'b0, 5'd8, 32'h0000_0001);

    do_store("sh46", 32'h46, 32'h1234_BEEF, 2'b01, 4'b1100, 32'hBEEF_BEEF);
    do_load("lh46", 32'h46, 2'b01, 1'b0, 5'd9, 32'hFFFF_BEEF);
    do_store("sb45", 32'h45, 32'h0000_007E, 2'b00, 4'b0010, 32'h7E7E_7E7E);
    do_load("lbu45", 32'h45, 2'b00, 1'b1, 5'd10, 32'h0000_007E);

    // faults
    do_fault("flw6", 1'b0, 32'h6, 2'b10, 5'd11);
    do_fault("fsw1000", 1'b1, 32'h1000, 2'b10, 5'd12);
    @(negedge clk);
    chk("errcnt2", 32'(err_count), 32'd2);
    do_fault("fsize3", 1'b0, 32'h10, 2'b11, 5'd13);
    do_fault("fsh41", 1'b1, 32'h41, 2'b01, 5'd14);
    @(negedge clk);
    chk("errcnt4", 32'(err_count), 32'd4);

    // backpressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    do_load("lwhold", 32'h40, 2'b10, 1'b0, 5'd15, 32'h8001_7F80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h40, 32'h0, 2'b10, 1'b0, 5'd0);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, 32'h8001_7F80);
      chk("hold_rd", 32'(rsp_rd), 32'd15);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_nowe", 32'(mem_we), 32'd0);
    end
    @(negedge clk);
    idle_req();
    rsp_ready = 1'b1;
    #1;
    chk("hold_last", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("hold_drop", 32'(rsp_valid), 32'd0);
    chk("hold_rdy", 32'(req_ready), 32'd1);
    do_load("lwafter", 32'h40, 2'b10, 1'b0, 5'd16, 32'h8001_7F80);

    // back-to-back word stores
    do_store("bb0", 32'h0, 32'h1111_1111, 2'b10, 4'b1111, 32'h1111_1111);
    do_store("bb1", 32'h4, 32'h2222_2222, 2'b10, 4'b1111, 32'h2222_2222);
    do_store("bb2", 32'h8, 32'h3333_3333, 2'b10, 4'b1111, 32'h3333_3333);
    do_store("bb3", 32'hC, 32'h4444_4444, 2'b10, 4'b1111, 32'h4444_4444);
    @(negedge clk);
    idle_req();
    #1;
    chk("bb_idle_we", 32'(mem_we), 32'd0);
    chk("bb_idle_strb", 32'(mem_wstrb), 32'd0);
    chk("bb_novalid", 32'(rsp_valid), 32'd0);
    do_load("lwC", 32'hC, 2'b10, 1'b0, 5'd17, 32'h4444_4444);
    do_load("lbu4", 32'h4, 2'b00, 1'b1, 5'd18, 32'h0000_0022);

    // reset during LWAIT discards the pending load
    @(negedge clk);
    drive(1'b0, 32'h8, 32'd0, 2'b10, 1'b0, 5'd19);
    @(negedge clk);
    idle_req();
    rst_n = 1'b0;
    #1;
    chk("rstlw_valid", 32'(rsp_valid), 32'd0);
    chk("rstlw_errcnt", 32'(err_count), 32'd0);
    chk("rstlw_rd", 32'(rsp_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstlw_ready", 32'(req_ready), 32'd1);
    chk("rstlw_valid2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rstlw_valid3", 32'(rsp_valid), 32'd0);

    // saturation
    do_fault("fsat0", 1'b0, 32'h2001, 2'b01, 5'd20);
    @(negedge clk);
    chk("errcnt1", 32'(err_count), 32'd1);
    force dut.err_count = 16'hFFFF;
    @(negedge clk);
    release dut.err_count;
    do_fault("fsat1", 1'b0, 32'h2001, 2'b01, 5'd21);
    @(negedge clk);
    chk("errcnt_sat", 32'(err_count), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
